// File: rtl/pspin_her_dispatch.sv
// rtl/pspin_her_dispatch.sv - per-context HER queues with credit-gated round-robin dispatch
module pspin_her_dispatch #(
    parameter int NUM_HANDLER_CTX = 4,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH       = 32,
    parameter int MSG_ID_WIDTH    = 10,
    parameter int FIFO_DEPTH      = 8,
    parameter int CREDITS         = 16,
    localparam int CTX_W          = (NUM_HANDLER_CTX > 1) ? $clog2(NUM_HANDLER_CTX) : 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_HANDLER_CTX-1:0] conf_enabled,
    input  logic [AXI_ADDR_WIDTH-1:0]  s_desc_addr,
    input  logic [LEN_WIDTH-1:0]       s_desc_len,
    input  logic [MSG_ID_WIDTH-1:0]    s_desc_msgid,
    input  logic [CTX_W-1:0]           s_desc_ctx,
    input  logic                       s_desc_valid,
    output logic                       s_desc_ready,
    output logic [AXI_ADDR_WIDTH-1:0]  m_her_addr,
    output logic [LEN_WIDTH-1:0]       m_her_len,
    output logic [MSG_ID_WIDTH-1:0]    m_her_msgid,
    output logic [CTX_W-1:0]           m_her_ctx,
    output logic                       m_her_valid,
    input  logic                       m_her_ready,
    input  logic                       fb_valid,
    input  logic [CTX_W-1:0]           fb_ctx,
    output logic                       fb_ready,
    output logic [31:0]                stat_dropped,
    output logic                       stat_fb_overflow
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int CRD_W   = 8;
    localparam int ENTRY_W = AXI_ADDR_WIDTH + LEN_WIDTH + MSG_ID_WIDTH;

    logic [ENTRY_W-1:0]         r_mem [NUM_HANDLER_CTX][FIFO_DEPTH];
    logic [CNT_W-1:0]           r_wptr [NUM_HANDLER_CTX];
    logic [CNT_W-1:0]           r_rptr [NUM_HANDLER_CTX];
    logic [CRD_W-1:0]           r_credit [NUM_HANDLER_CTX];
    logic [CTX_W-1:0]           r_rr_ptr;
    logic                       r_valid;
    logic [ENTRY_W-1:0]         r_data;
    logic [CTX_W-1:0]           r_ctx;
    logic [31:0]                r_dropped;
    logic                       r_fb_ovf;

    logic [NUM_HANDLER_CTX-1:0] w_full;
    logic [NUM_HANDLER_CTX-1:0] w_elig;
    logic [NUM_HANDLER_CTX-1:0] w_push;
    logic [NUM_HANDLER_CTX-1:0] w_pop;
    logic [NUM_HANDLER_CTX-1:0] w_crd_inc;
    logic                       w_desc_in_range;
    logic                       w_desc_en;
    logic                       w_desc_hs;
    logic                       w_fb_in_range;
    logic                       w_fb_ovf;
    logic                       w_grant_found;
    logic [CTX_W-1:0]           w_grant_ctx;
    logic                       w_out_free;
    logic                       w_load;

    assign w_desc_in_range = (32'(s_desc_ctx) < NUM_HANDLER_CTX);
    assign w_desc_en       = w_desc_in_range && conf_enabled[s_desc_ctx];
    assign s_desc_ready    = !w_desc_en || !w_full[s_desc_ctx];
    assign w_desc_hs       = s_desc_valid && s_desc_ready;
    assign w_fb_in_range   = (32'(fb_ctx) < NUM_HANDLER_CTX);
    assign w_out_free      = !r_valid || m_her_ready;
    assign w_load          = w_out_free && w_grant_found;

    // Per-context queue status, eligibility, push/pop strobes and credit return
    always_comb begin
        w_full    = '0;
        w_elig    = '0;
        w_push    = '0;
        w_pop     = '0;
        w_crd_inc = '0;
        w_fb_ovf  = 1'b0;
        for (int c = 0; c < NUM_HANDLER_CTX; c++) begin
            w_full[c]    = ((r_wptr[c] - r_rptr[c]) == CNT_W'(FIFO_DEPTH));
            w_elig[c]    = (r_wptr[c] != r_rptr[c]) && conf_enabled[c] && (r_credit[c] != '0);
            w_push[c]    = w_desc_hs && w_desc_en && (s_desc_ctx == CTX_W'(c));
            w_pop[c]     = w_load && (w_grant_ctx == CTX_W'(c));
            // A grant in the same cycle frees room, so feedback at full credit is then legal
            w_crd_inc[c] = fb_valid && w_fb_in_range && (fb_ctx == CTX_W'(c)) &&
                           ((r_credit[c] != CRD_W'(CREDITS)) || w_pop[c]);
            if (fb_valid && (fb_ctx == CTX_W'(c)) && !w_crd_inc[c])
                w_fb_ovf = 1'b1;
        end
        if (fb_valid && !w_fb_in_range)
            w_fb_ovf = 1'b1;
    end

    // Round-robin search: first eligible context at or after r_rr_ptr
    always_comb begin
        logic [CTX_W-1:0] v_idx;
        w_grant_found = 1'b0;
        w_grant_ctx   = '0;
        v_idx         = '0;
        for (int i = 0; i < NUM_HANDLER_CTX; i++) begin
            v_idx = r_rr_ptr + CTX_W'(i);
            if (!w_grant_found && w_elig[v_idx]) begin
                w_grant_found = 1'b1;
                w_grant_ctx   = v_idx;
            end
        end
    end

    // Queue storage; contents are meaningless until pointers say otherwise, so no reset
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_HANDLER_CTX; c++) begin
            if (w_push[c])
                r_mem[c][r_wptr[c][PTR_W-1:0]] <= {s_desc_addr, s_desc_len, s_desc_msgid};
        end
    end

    // Queue pointers and credit counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < NUM_HANDLER_CTX; c++) begin
                r_wptr[c]   <= '0;
                r_rptr[c]   <= '0;
                r_credit[c] <= CRD_W'(CREDITS);
            end
        end else begin
            for (int c = 0; c < NUM_HANDLER_CTX; c++) begin
                if (w_push[c])
                    r_wptr[c] <= r_wptr[c] + CNT_W'(1);
                if (w_pop[c])
                    r_rptr[c] <= r_rptr[c] + CNT_W'(1);
                if (w_crd_inc[c] && !w_pop[c])
                    r_credit[c] <= r_credit[c] + CRD_W'(1);
                else if (!w_crd_inc[c] && w_pop[c])
                    r_credit[c] <= r_credit[c] - CRD_W'(1);
            end
        end
    end

    // Output register and arbiter pointer; the register holds while stalled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_ctx    <= '0;
            r_rr_ptr <= '0;
        end else if (w_out_free) begin
            r_valid <= w_grant_found;
            if (w_grant_found) begin
                r_data   <= r_mem[w_grant_ctx][r_rptr[w_grant_ctx][PTR_W-1:0]];
                r_ctx    <= w_grant_ctx;
                r_rr_ptr <= w_grant_ctx + CTX_W'(1);
            end
        end
    end

    // Statistics: saturating drop count and sticky feedback overflow flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dropped <= '0;
            r_fb_ovf  <= 1'b0;
        end else begin
            if (w_desc_hs && !w_desc_en && (r_dropped != 32'hFFFF_FFFF))
                r_dropped <= r_dropped + 32'd1;
            if (w_fb_ovf)
                r_fb_ovf <= 1'b1;
        end
    end

    assign m_her_valid      = r_valid;
    assign m_her_addr       = r_data[ENTRY_W-1 -: AXI_ADDR_WIDTH];
    assign m_her_len        = r_data[MSG_ID_WIDTH +: LEN_WIDTH];
    assign m_her_msgid      = r_data[MSG_ID_WIDTH-1:0];
    assign m_her_ctx        = r_ctx;
    assign fb_ready         = 1'b1;
    assign stat_dropped     = r_dropped;
    assign stat_fb_overflow = r_fb_ovf;

endmodule
